ra_bist_rd_check: RTL and testbench

// - Read-data checker downstream of the BIST port mux: consumes array rd0/rd1 read data and compares it against expected data issued with each BIST read.
// - Aligns expected data to array read latency, logs sticky fail, miscompare count, first-fail address/port/syndrome, and raises done/pass at end of test.
// - Results are exported as a 32-bit status word for the wrapper status port and GPIO/wishbone readout.

---
 rtl/ra_bist_rd_check_pkg.sv | 23 ++
 rtl/ra_bist_dly.sv | 45 ++++
 rtl/ra_bist_rd_check.sv | 124 ++++++++++++
 tb/tb_ra_bist_rd_check.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ra_bist_rd_check_pkg.sv
// Shared FSM encoding and status-word layout for the BIST read-data checker.
package ra_bist_rd_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int NUM_PORTS   = 2;

  localparam int STS_DONE    = 0;
  localparam int STS_PASS    = 1;
  localparam int STS_FAIL    = 2;
  localparam int STS_BUSY    = 3;
  localparam int STS_PORT    = 4;
  localparam int STS_ADR_LSB = 8;
  localparam int STS_ADR_W   = 6;
  localparam int STS_CNT_LSB = 16;
  localparam int STS_CNT_W   = 8;

endpackage

// File: rtl/ra_bist_dly.sv
// RD_LAT-deep delay of a check request so expected data meets the array read data.
module ra_bist_dly #(
  parameter int RD_LAT = 1,
  parameter int ADR_W  = 6,
  parameter int DAT_W  = 72
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [ADR_W-1:0] in_adr,
  input  logic [DAT_W-1:0] in_exp,
  output logic             out_vld,
  output logic [ADR_W-1:0] out_adr,
  output logic [DAT_W-1:0] out_exp
);

  logic [RD_LAT-1:0]            vld_pipe;
  logic [RD_LAT-1:0][ADR_W-1:0] adr_pipe;
  logic [RD_LAT-1:0][DAT_W-1:0] exp_pipe;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Payload is qualified by the valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    adr_pipe[0] <= in_adr;
    exp_pipe[0] <= in_exp;
    for (int i = 1; i < RD_LAT; i++) begin
      adr_pipe[i] <= adr_pipe[i-1];
      exp_pipe[i] <= exp_pipe[i-1];
    end
  end

  assign out_vld = vld_pipe[RD_LAT-1];
  assign out_adr = adr_pipe[RD_LAT-1];
  assign out_exp = exp_pipe[RD_LAT-1];

endmodule

// File: rtl/ra_bist_rd_check.sv
// Compares array read data against latency-aligned expected data and logs
// sticky fail, saturating miscompare count and first-fail info.
module ra_bist_rd_check
  import ra_bist_rd_check_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int DAT_W  = 72,
  parameter int ADR_W  = 6,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             end_of_test,
  input  logic             chk0_enb,
  input  logic [ADR_W-1:0] chk0_adr,
  input  logic [DAT_W-1:0] chk0_exp,
  input  logic             chk1_enb,
  input  logic [ADR_W-1:0] chk1_adr,
  input  logic [DAT_W-1:0] chk1_exp,
  input  logic [DAT_W-1:0] rd0_dat,
  input  logic [DAT_W-1:0] rd1_dat,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             ff_port,
  output logic [ADR_W-1:0] ff_adr,
  output logic [DAT_W-1:0] ff_syn,
  output logic [31:0]      status
);

  localparam int DCW = $clog2(RD_LAT + 1);

  state_e         state;
  logic [DCW-1:0] drain_cnt;

  logic [NUM_PORTS-1:0]            chk_enb, d_vld, mis;
  logic [NUM_PORTS-1:0][ADR_W-1:0] chk_adr, d_adr;
  logic [NUM_PORTS-1:0][DAT_W-1:0] chk_exp, d_exp, rd_dat, syn;
  logic [CNT_W:0]                  cnt_sum;

  assign chk_enb = {chk1_enb, chk0_enb};
  assign chk_adr = {chk1_adr, chk0_adr};
  assign chk_exp = {chk1_exp, chk0_exp};
  assign rd_dat  = {rd1_dat, rd0_dat};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    ra_bist_dly #(.RD_LAT(RD_LAT), .ADR_W(ADR_W), .DAT_W(DAT_W)) u_dly (
      .clk     (clk),
      .reset   (reset),
      .clr     (start),
      .in_vld  (chk_enb[p] && (state == ST_RUN)),
      .in_adr  (chk_adr[p]),
      .in_exp  (chk_exp[p]),
      .out_vld (d_vld[p]),
      .out_adr (d_adr[p]),
      .out_exp (d_exp[p])
    );
    assign syn[p] = rd_dat[p] ^ d_exp[p];
    assign mis[p] = d_vld[p] && (|syn[p]);
  end

  // One extra bit catches overflow when both ports fail on a near-full count.
  assign cnt_sum = {1'b0, fail_cnt} + (CNT_W+1)'(mis[0]) + (CNT_W+1)'(mis[1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      fail      <= 1'b0;
      fail_cnt  <= '0;
      ff_port   <= 1'b0;
      ff_adr    <= '0;
      ff_syn    <= '0;
    end else if (start) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      fail      <= 1'b0;
      fail_cnt  <= '0;
      ff_port   <= 1'b0;
      ff_adr    <= '0;
      ff_syn    <= '0;
    end else begin
      if (|mis) begin
        fail     <= 1'b1;
        fail_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        if (!fail) begin
          ff_port <= !mis[0];
          ff_adr  <= mis[0] ? d_adr[0] : d_adr[1];
          ff_syn  <= mis[0] ? syn[0]   : syn[1];
        end
      end
      case (state)
        ST_RUN: if (end_of_test) begin
          state     <= ST_DRAIN;
          drain_cnt <= '0;
        end
        ST_DRAIN: begin
          if (drain_cnt == DCW'(RD_LAT - 1)) state <= ST_DONE;
          else drain_cnt <= drain_cnt + DCW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);
  assign pass = (state == ST_DONE) && !fail;

  always_comb begin
    status = '0;
    status[STS_DONE] = done;
    status[STS_PASS] = pass;
    status[STS_FAIL] = fail;
    status[STS_BUSY] = busy;
    status[STS_PORT] = ff_port;
    status[STS_ADR_LSB +: STS_ADR_W] = STS_ADR_W'(ff_adr);
    status[STS_CNT_LSB +: STS_CNT_W] = STS_CNT_W'(fail_cnt);
  end

endmodule

// File: tb/tb_ra_bist_rd_check.sv
// Scoreboard bench for ra_bist_rd_check: per-check outcomes are queued at issue
// and folded into a reference log when they are due to appear on the outputs.
module tb_ra_bist_rd_check;

  localparam int RD_LAT  = 1;
  localparam int DAT_W   = 72;
  localparam int ADR_W   = 6;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, start, end_of_test;
  logic             chk0_enb, chk1_enb;
  logic [ADR_W-1:0] chk0_adr, chk1_adr;
  logic [DAT_W-1:0] chk0_exp, chk1_exp, rd0_dat, rd1_dat;
  logic             busy, done, pass, fail, ff_port;
  logic [CNT_W-1:0] fail_cnt;
  logic [ADR_W-1:0] ff_adr;
  logic [DAT_W-1:0] ff_syn;
  logic [31:0]      status;

  ra_bist_rd_check #(.RD_LAT(RD_LAT), .DAT_W(DAT_W), .ADR_W(ADR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .end_of_test(end_of_test),
    .chk0_enb(chk0_enb), .chk0_adr(chk0_adr), .chk0_exp(chk0_exp),
    .chk1_enb(chk1_enb), .chk1_adr(chk1_adr), .chk1_exp(chk1_exp),
    .rd0_dat(rd0_dat), .rd1_dat(rd1_dat),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .fail_cnt(fail_cnt),
    .ff_port(ff_port), .ff_adr(ff_adr), .ff_syn(ff_syn), .status(status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Array model: read data arrives RD_LAT cycles after the check is issued.
  logic [DAT_W-1:0] act0 = '0, act1 = '0;
  logic [RD_LAT-1:0][DAT_W-1:0] rp0, rp1;
  always @(posedge clk) begin
    rp0[0] <= act0;
    rp1[0] <= act1;
    for (int i = 1; i < RD_LAT; i++) begin
      rp0[i] <= rp0[i-1];
      rp1[i] <= rp1[i-1];
    end
  end
  assign rd0_dat = rp0[RD_LAT-1];
  assign rd1_dat = rp1[RD_LAT-1];

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [DAT_W-1:0] got, input logic [DAT_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int               due;
    logic             m0, m1;
    logic [ADR_W-1:0] a0, a1;
    logic [DAT_W-1:0] s0, s1;
  } ent_t;
  ent_t sb[$];

  // Reference log state
  logic             r_fail;
  int               r_cnt;
  logic             r_port;
  logic [ADR_W-1:0] r_adr;
  logic [DAT_W-1:0] r_syn;

  task automatic model_clear();
    sb.delete();
    r_fail = 0; r_cnt = 0; r_port = 0; r_adr = '0; r_syn = '0;
  endtask

  ent_t e;
  bit   popped;
  always @(negedge clk) begin
    popped = 0;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      popped = 1;
      if (e.m0 || e.m1) begin
        if (!r_fail) begin
          r_port = !e.m0;
          r_adr  = e.m0 ? e.a0 : e.a1;
          r_syn  = e.m0 ? e.s0 : e.s1;
        end
        r_fail = 1;
        r_cnt  = r_cnt + int'(e.m0) + int'(e.m1);
        if (r_cnt > CNT_MAX) r_cnt = CNT_MAX;
      end
    end
    if (popped) begin
      chk("sb_fail",    fail,     r_fail);
      chk("sb_cnt",     fail_cnt, r_cnt);
      chk("sb_ff_port", ff_port,  r_port);
      chk("sb_ff_adr",  ff_adr,   r_adr);
      chk("sb_ff_syn",  ff_syn,   r_syn);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic issue(input logic e0, input logic [ADR_W-1:0] a0, input logic [DAT_W-1:0] x0,
                       input logic [DAT_W-1:0] r0,
                       input logic e1, input logic [ADR_W-1:0] a1, input logic [DAT_W-1:0] x1,
                       input logic [DAT_W-1:0] r1, input bit acc, input bit eot);
    chk0_enb = e0; chk0_adr = a0; chk0_exp = x0; act0 = r0;
    chk1_enb = e1; chk1_adr = a1; chk1_exp = x1; act1 = r1;
    end_of_test = eot;
    if (acc && (e0 || e1))
      sb.push_back('{cyc + 1 + RD_LAT, e0 && (r0 != x0), e1 && (r1 != x1), a0, a1, r0 ^ x0, r1 ^ x1});
    step();
    chk0_enb = 0; chk1_enb = 0; end_of_test = 0;
  endtask

  task automatic do_start();
    start = 1;
    model_clear();
    step();
    start = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    model_clear();
    repeat (n) step();
    reset = 0;
  endtask

  // Called in the cycle after end_of_test: done must rise exactly RD_LAT+1 cycles after it.
  task automatic finish_run(input string tag);
    repeat (RD_LAT - 1) step();
    sample();
    chk({tag, "_done_early"}, done, 1'b0);
    chk({tag, "_busy_drain"}, busy, 1'b1);
    step();
    sample();
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_done"}, busy, 1'b0);
  endtask

  localparam logic [DAT_W-1:0] ONES = '1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; start = 0; end_of_test = 0;
    chk0_enb = 0; chk0_adr = '0; chk0_exp = '0;
    chk1_enb = 0; chk1_adr = '0; chk1_exp = '0;
    model_clear();

    // Reset state
    do_reset(3);
    sample();
    chk("rst_status", status, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cnt", fail_cnt, 0);
    chk("rst_syn", ff_syn, '0);

    // All-pass run: 64 port-0 checks of zero data
    do_start();
    sample();
    chk("ap_busy", busy, 1'b1);
    for (int i = 0; i < 64; i++)
      issue(1, ADR_W'(i), '0, '0, 0, '0, '0, '0, 1, i == 63);
    finish_run("ap");
    chk("ap_pass", pass, 1'b1);
    chk("ap_cnt", fail_cnt, 0);
    chk("ap_status", status, 32'h0000_0003);

    // Single port-1 fail, bit 5 dropped
    do_start();
    issue(0, '0, '0, '0, 1, 6'h2A, ONES, ONES ^ 72'h20, 1, 1);
    repeat (RD_LAT - 1) step();
    sample();
    chk("sf_fail_early", fail, 1'b0);
    step();
    sample();
    chk("sf_fail", fail, 1'b1);
    chk("sf_done", done, 1'b1);
    chk("sf_pass", pass, 1'b0);
    chk("sf_ff_port", ff_port, 1'b1);
    chk("sf_ff_adr", ff_adr, 6'h2A);
    chk("sf_ff_syn", ff_syn, 72'h20);
    chk("sf_cnt", fail_cnt, 1);
    chk("sf_status", status, 32'h0001_2A15);

    // Restart from DONE after a fail
    do_start();
    sample();
    chk("rs_fail", fail, 1'b0);
    chk("rs_cnt", fail_cnt, 0);
    chk("rs_ff_port", ff_port, 1'b0);
    chk("rs_ff_adr", ff_adr, 0);
    chk("rs_ff_syn", ff_syn, '0);
    chk("rs_status", status, 32'h0000_0008);

    // Dual same-cycle fail: port 0 wins first-fail
    issue(1, 6'h05, '0, 72'h1, 1, 6'h06, '0, 72'h2, 1, 1);
    finish_run("df");
    chk("df_cnt", fail_cnt, 2);
    chk("df_ff_port", ff_port, 1'b0);
    chk("df_ff_adr", ff_adr, 6'h05);
    chk("df_ff_syn", ff_syn, 72'h1);
    chk("df_pass", pass, 1'b0);

    // Saturation: 300 port-0 fails plus every third cycle on port 1
    do_start();
    for (int i = 0; i < 300; i++)
      issue(1, ADR_W'(i + 17), '0, DAT_W'(i + 1),
            (i % 3) == 2, ADR_W'(i), ONES, '0, 1, i == 299);
    finish_run("sat");
    chk("sat_cnt", fail_cnt, 8'hFF);
    chk("sat_ff_adr", ff_adr, 6'h11);
    chk("sat_ff_syn", ff_syn, 72'h1);
    chk("sat_ff_port", ff_port, 1'b0);
    chk("sat_status", status, 32'h00FF_1105);

    // Drain: fail issued with end_of_test is logged; later checks ignored
    do_start();
    issue(1, 6'h01, 72'h5, 72'h5, 0, '0, '0, '0, 1, 0);
    issue(1, 6'h33, '0, 72'h80, 0, '0, '0, '0, 1, 1);
    chk1_enb = 1; chk1_adr = 6'h3F; chk1_exp = '0; act1 = ONES;
    sample();
    chk("dr_done_early", done, 1'b0);
    chk("dr_fail_early", fail, 1'b0);
    step();
    sample();
    chk("dr_done", done, 1'b1);
    chk("dr_fail", fail, 1'b1);
    chk("dr_ff_adr", ff_adr, 6'h33);
    chk1_enb = 0; act1 = '0;
    repeat (3) step();
    sample();
    chk("dr_cnt_hold", fail_cnt, 1);
    chk("dr_ff_port", ff_port, 1'b0);

    // start beats a simultaneous end_of_test
    do_start();
    start = 1; end_of_test = 1;
    model_clear();
    step();
    start = 0; end_of_test = 0;
    repeat (RD_LAT + 2) step();
    sample();
    chk("sw_busy", busy, 1'b1);
    chk("sw_done", done, 1'b0);

    // Reset mid-RUN aborts an in-flight fail
    issue(1, 6'h0A, '0, ONES, 1, 6'h0B, '0, ONES, 1, 0);
    do_reset(1);
    sample();
    chk("rm_status", status, 32'h0);
    chk("rm_fail", fail, 1'b0);
    chk("rm_cnt", fail_cnt, 0);
    chk("rm_syn", ff_syn, '0);

    // Checks in IDLE are ignored
    issue(1, 6'h0C, '0, ONES, 0, '0, '0, '0, 0, 0);
    repeat (RD_LAT + 2) step();
    sample();
    chk("idle_fail", fail, 1'b0);
    chk("idle_status", status, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
